wb_master_burst: RTL
====================

Name: wb_master_burst

Overview:
Next-generation Wishbone B4 classic-cycle master between the CPU/cache side and the WB interconnect. Supports single and incrementing-burst transfers of up to MAX_BEATS beats with CTI/BTE tagging. Handles slave ERR_I and RTY_I, with bounded automatic retry, and aborts a stalled cycle with a watchdog timeout. Every transfer ends with a done pulse and a status code.

Parameters:
ADDR_WIDTH, 32, address width in bits.
DATA_WIDTH, 32, data width in bits (multiple of 8).
MAX_BEATS, 8, maximum beats per burst (power of 2, >=2).
MAX_RETRIES, 3, consecutive RTY_I responses tolerated per beat.
TIMEOUT_CYCLES, 255, STB_O-high cycles without a slave response before abort (>=2).

Ports:
clk_i  in  1  clock, rising edge.
rst_ni  in  1  asynchronous active-low reset.
start_rd_i  in  1  request a read transfer; sampled only in IDLE.
start_wr_i  in  1  request a write transfer; sampled only in IDLE.
beats_i  in  $clog2(MAX_BEATS)  beat count minus 1 (0 = single).
addr_i  in  ADDR_WIDTH  start byte address.
sel_i  in  DATA_WIDTH/8  byte select, applied to every beat.
wdata_i  in  DATA_WIDTH  write data for the next beat; sampled when wdata_ready_o=1.
wdata_ready_o  out  1  combinational: wdata_i is loaded into DAT_O at this edge.
rdata_o  out  DATA_WIDTH  read beat data.
rdata_valid_o  out  1  one-cycle pulse per read beat.
busy_o  out  1  transfer in progress (state != IDLE).
done_o  out  1  one-cycle pulse at end of transfer.
status_o  out  2  valid with done_o: 00 ok, 01 bus error, 10 retries exhausted, 11 timeout.
DAT_I  in  DATA_WIDTH  WB read data.
ADR_O  out  ADDR_WIDTH  WB address.
DAT_O  out  DATA_WIDTH  WB write data.
WE_O  out  1  WB write enable.
SEL_O  out  DATA_WIDTH/8  WB byte select.
STB_O  out  1  WB strobe.
CYC_O  out  1  WB cycle.
CTI_O  out  3  cycle type: 000 single, 010 incrementing burst, 111 end of burst.
BTE_O  out  2  burst type; always 00 (linear).
ACK_I  in  1  WB acknowledge.
ERR_I  in  1  WB error.
RTY_I  in  1  WB retry.

Behaviour:
- Reset (rst_ni=0, async): state IDLE. All outputs 0, including CYC_O and STB_O. Counters cleared. Reset during a transfer drops the cycle immediately and produces no done_o.
- States: IDLE, ACTIVE, RETRY_GAP, FINISH. All WB outputs and status outputs are registered.
- Start: in IDLE, start_rd_i has priority over start_wr_i. On acceptance the block latches beats_i, addr_i, sel_i and WE. In the next cycle it enters ACTIVE with CYC_O=STB_O=1 and ADR_O=addr_i.
- Write data: for writes, wdata_ready_o=1 in the accepting cycle and in every ACK cycle that is not the last beat.
- CTI_O: 000 if beats_i=0. Otherwise 010 on every beat except the last, which is 111.
- ACK_I in ACTIVE:
  - read: rdata_o<=DAT_I, rdata_valid_o pulses next cycle.
  - not last beat: ADR_O += DATA_WIDTH/8 (wraps modulo 2^ADDR_WIDTH); STB_O stays high (back-to-back beats, 1 beat/cycle).
  - last beat: go to FINISH; CYC_O=STB_O=0, done_o=1, status 00 next cycle.
- FINISH lasts one cycle, then IDLE. Starts are ignored while busy_o=1.
- Response priority, if asserted together: ERR_I > RTY_I > ACK_I.
- ERR_I: abort. CYC_O/STB_O drop next cycle, done_o=1, status 01. Remaining beats are discarded.
- RTY_I: drop CYC_O/STB_O for exactly one cycle (RETRY_GAP), then re-issue the same beat with the same ADR_O/DAT_O. The retry counter increments; an RTY_I when the counter already equals MAX_RETRIES aborts with status 10. The counter clears on each ACK.
- Timeout: a counter runs while STB_O=1 and no response arrives. It clears on any response or on entering RETRY_GAP. Reaching TIMEOUT_CYCLES aborts with status 11.
- Responses while STB_O=0 are ignored.
- Latency: single read with ACK_I in the first STB cycle: start at cycle 0, STB at cycle 1, rdata_valid_o/done_o at cycle 2, next start accepted at cycle 3.

Test Plan:
- Single read, addr 0x100, slave ACKs in 1st STB cycle with DAT_I=0xDEADBEEF -> ADR_O=0x100, CTI_O=000, rdata_o=0xDEADBEEF, done_o at cycle 2, status 00.
- 4-beat write at 0x200, sel=0xF, wdata 1,2,3,4 -> ADR_O 0x200/204/208/20C, CTI 010,010,010,111, DAT_O 1..4, four wdata_ready_o pulses, done status 00.
- 4-beat read with slave wait states (ACK every 2nd cycle) -> 4 rdata_valid_o pulses in order, STB_O held high throughout, single done_o.
- Write, slave asserts RTY_I twice then ACK -> two 1-cycle CYC_O gaps, same ADR_O/DAT_O re-issued, status 00. With 4 RTYs and MAX_RETRIES=3 -> status 10.
- Beat 2 of a 4-beat read gets ERR_I+ACK_I together -> ERR wins, only 1 rdata_valid_o, status 01; slave never responds on a new transfer -> abort after 255 STB cycles, status 11.
- rst_ni low mid-burst -> CYC_O/STB_O low immediately, no done_o; after release a new single write completes normally.

Source files
------------

// File: rtl/wb_master_burst.sv
// Wishbone B4 classic-cycle burst master: single/incrementing bursts with CTI tagging,
// ERR abort, bounded RTY re-issue and a watchdog on an unanswered strobe.
//
// state     | meaning
// IDLE      | waiting for start_rd_i / start_wr_i
// ACTIVE    | CYC_O/STB_O high, waiting for a slave response
// RETRY_GAP | one-cycle bus release after RTY_I, same beat re-issued next
// FINISH    | done_o/status_o valid for one cycle, then back to IDLE
module wb_master_burst #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int MAX_BEATS      = 8,
    parameter int MAX_RETRIES    = 3,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          start_rd_i,
    input  logic                          start_wr_i,
    input  logic [$clog2(MAX_BEATS)-1:0]  beats_i,
    input  logic [ADDR_WIDTH-1:0]         addr_i,
    input  logic [DATA_WIDTH/8-1:0]       sel_i,
    input  logic [DATA_WIDTH-1:0]         wdata_i,
    output logic                          wdata_ready_o,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic                          rdata_valid_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [1:0]                    status_o,
    input  logic [DATA_WIDTH-1:0]         DAT_I,
    output logic [ADDR_WIDTH-1:0]         ADR_O,
    output logic [DATA_WIDTH-1:0]         DAT_O,
    output logic                          WE_O,
    output logic [DATA_WIDTH/8-1:0]       SEL_O,
    output logic                          STB_O,
    output logic                          CYC_O,
    output logic [2:0]                    CTI_O,
    output logic [1:0]                    BTE_O,
    input  logic                          ACK_I,
    input  logic                          ERR_I,
    input  logic                          RTY_I
);

    localparam int BEAT_W  = $clog2(MAX_BEATS);
    localparam int SEL_W   = DATA_WIDTH / 8;
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [RETRY_W-1:0]    RETRY_MAX = RETRY_W'(MAX_RETRIES);
    localparam logic [TMO_W-1:0]      TMO_INIT  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ADDR_WIDTH-1:0] ADR_STEP  = ADDR_WIDTH'(SEL_W);
    localparam logic [BEAT_W-1:0]     BEAT_ONE  = BEAT_W'(1);

    localparam logic [2:0] CTI_SINGLE = 3'b000;
    localparam logic [2:0] CTI_INCR   = 3'b010;
    localparam logic [2:0] CTI_END    = 3'b111;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BUS_ERR = 2'b01;
    localparam logic [1:0] ST_RETRY   = 2'b10;
    localparam logic [1:0] ST_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        RETRY_GAP = 2'd2,
        FINISH    = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [BEAT_W-1:0]      beats_q, beats_d;
    logic [BEAT_W-1:0]      beat_cnt_q, beat_cnt_d;
    logic [RETRY_W-1:0]     retry_cnt_q, retry_cnt_d;
    logic [TMO_W-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic [ADDR_WIDTH-1:0]  adr_q, adr_d;
    logic [DATA_WIDTH-1:0]  dat_o_q, dat_o_d;
    logic [SEL_W-1:0]       sel_q, sel_d;
    logic                   we_q, we_d;
    logic                   cyc_q, cyc_d;
    logic                   stb_q, stb_d;
    logic [2:0]             cti_q, cti_d;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                   rdata_valid_q, rdata_valid_d;
    logic                   done_q, done_d;
    logic [1:0]             status_q, status_d;
    logic                   wrdy;
    logic                   last_beat;
    logic [BEAT_W-1:0]      beat_nxt;

    assign last_beat = (beat_cnt_q == beats_q);
    assign beat_nxt  = beat_cnt_q + BEAT_ONE;

    always_comb begin
        state_d       = state_q;
        beats_d       = beats_q;
        beat_cnt_d    = beat_cnt_q;
        retry_cnt_d   = retry_cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        adr_d         = adr_q;
        dat_o_d       = dat_o_q;
        sel_d         = sel_q;
        we_d          = we_q;
        cyc_d         = cyc_q;
        stb_d         = stb_q;
        cti_d         = cti_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        done_d        = 1'b0;
        status_d      = status_q;
        wrdy          = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start_rd_i || start_wr_i) begin
                    state_d     = ACTIVE;
                    we_d        = !start_rd_i;
                    beats_d     = beats_i;
                    beat_cnt_d  = '0;
                    retry_cnt_d = '0;
                    tmo_cnt_d   = TMO_INIT;
                    adr_d       = addr_i;
                    sel_d       = sel_i;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    cti_d       = (beats_i == '0) ? CTI_SINGLE : CTI_INCR;
                    if (!start_rd_i) begin
                        wrdy    = 1'b1;
                        dat_o_d = wdata_i;
                    end
                end
            end

            ACTIVE: begin
                if (ERR_I) begin
                    state_d  = FINISH;
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    done_d   = 1'b1;
                    status_d = ST_BUS_ERR;
                end else if (RTY_I) begin
                    if (retry_cnt_q == RETRY_MAX) begin
                        state_d  = FINISH;
                        cyc_d    = 1'b0;
                        stb_d    = 1'b0;
                        done_d   = 1'b1;
                        status_d = ST_RETRY;
                    end else begin
                        state_d     = RETRY_GAP;
                        retry_cnt_d = retry_cnt_q + RETRY_W'(1);
                        tmo_cnt_d   = TMO_INIT;
                        cyc_d       = 1'b0;
                        stb_d       = 1'b0;
                    end
                end else if (ACK_I) begin
                    retry_cnt_d = '0;
                    tmo_cnt_d   = TMO_INIT;
                    if (!we_q) begin
                        rdata_d       = DAT_I;
                        rdata_valid_d = 1'b1;
                    end
                    if (last_beat) begin
                        state_d  = FINISH;
                        cyc_d    = 1'b0;
                        stb_d    = 1'b0;
                        done_d   = 1'b1;
                        status_d = ST_OK;
                    end else begin
                        beat_cnt_d = beat_nxt;
                        adr_d      = adr_q + ADR_STEP;
                        cti_d      = (beat_nxt == beats_q) ? CTI_END : CTI_INCR;
                        if (we_q) begin
                            wrdy    = 1'b1;
                            dat_o_d = wdata_i;
                        end
                    end
                end else if (tmo_cnt_q == '0) begin
                    state_d  = FINISH;
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    done_d   = 1'b1;
                    status_d = ST_TIMEOUT;
                end else begin
                    tmo_cnt_d = tmo_cnt_q - TMO_W'(1);
                end
            end

            // Address, data and CTI are untouched so the same beat goes out again.
            RETRY_GAP: begin
                state_d = ACTIVE;
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
            end

            FINISH: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            beats_q       <= '0;
            beat_cnt_q    <= '0;
            retry_cnt_q   <= '0;
            tmo_cnt_q     <= '0;
            adr_q         <= '0;
            dat_o_q       <= '0;
            sel_q         <= '0;
            we_q          <= 1'b0;
            cyc_q         <= 1'b0;
            stb_q         <= 1'b0;
            cti_q         <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            done_q        <= 1'b0;
            status_q      <= '0;
        end else begin
            state_q       <= state_d;
            beats_q       <= beats_d;
            beat_cnt_q    <= beat_cnt_d;
            retry_cnt_q   <= retry_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            adr_q         <= adr_d;
            dat_o_q       <= dat_o_d;
            sel_q         <= sel_d;
            we_q          <= we_d;
            cyc_q         <= cyc_d;
            stb_q         <= stb_d;
            cti_q         <= cti_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            done_q        <= done_d;
            status_q      <= status_d;
        end
    end

    assign wdata_ready_o = wrdy;
    assign rdata_o       = rdata_q;
    assign rdata_valid_o = rdata_valid_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign status_o      = status_q;
    assign ADR_O         = adr_q;
    assign DAT_O         = dat_o_q;
    assign WE_O          = we_q;
    assign SEL_O         = sel_q;
    assign STB_O         = stb_q;
    assign CYC_O         = cyc_q;
    assign CTI_O         = cti_q;
    assign BTE_O         = 2'b00;

endmodule
